sha_txn_master: RTL and testbench

Transaction initiator for the SHA-256 accelerator's three-bus protocol (transaction, data, ack). The master sits on the memory side of the accelerator. A host pulses `start` with a 256-bit message. The master then runs the full exchange: LOAD_TEXT streaming 32 bytes, HASH request, WRITE_RESULT with 32 digest bytes received, and ack handshake. It returns the 256-bit digest to the host with a `done` pulse.

---
 rtl/sha_txn_master.sv | 215 +++++++++++++++++++++
 tb/tb_sha_txn_master.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha_txn_master.sv
// Memory-side initiator for the SHA-256 accelerator: streams a 32-byte message,
// issues HASH, collects 32 digest bytes and completes the ack handshake.
// Optional per-phase watchdog: define SHA_MASTER_TIMEOUT_EN.
module sha_txn_master #(
  parameter int HASH_HOLD      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] msg,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [255:0] digest,
  output logic [1:0]   opcode,
  output logic [1:0]   source_id,
  output logic [1:0]   dest_id,
  output logic         encdec,
  output logic [23:0]  addr,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  input  logic         ack_valid,
  output logic         ack_ready,
  input  logic [1:0]   ack_source_id
);

  localparam logic [1:0] OP_NEUTRAL = 2'b00;
  localparam logic [1:0] OP_LOAD_TX = 2'b01;
  localparam logic [1:0] OP_WR_RES  = 2'b10;
  localparam logic [1:0] OP_HASH    = 2'b11;
  localparam logic [1:0] ID_MEM     = 2'b00;
  localparam logic [1:0] ID_SHA     = 2'b01;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HASH, S_RD_RES, S_WAIT_ACK, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [255:0]   sh_q, sh_d;
  logic [255:0]   cap_q, cap_d;
  logic [255:0]   digest_q, digest_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [1:0]     opcode_q, opcode_d, src_q, src_d, dst_q, dst_d;
  logic           busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic           tx_valid_q, tx_valid_d, rx_ready_q, rx_ready_d, ack_ready_q, ack_ready_d;

`ifdef SHA_MASTER_TIMEOUT_EN
  logic [15:0]    wd_q, wd_d;
  logic           progress;
`else
  logic           unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cap_d       = cap_q;
    digest_d    = digest_q;
    cnt_d       = cnt_q;
    opcode_d    = opcode_q;
    src_d       = src_q;
    dst_d       = dst_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    tx_valid_d  = tx_valid_q;
    rx_ready_d  = rx_ready_q;
    ack_ready_d = ack_ready_q;

    unique case (state_q)
      S_IDLE: if (start) begin
        sh_d       = msg;
        cnt_d      = '0;
        busy_d     = 1'b1;
        opcode_d   = OP_LOAD_TX;
        src_d      = ID_MEM;
        dst_d      = ID_SHA;
        tx_valid_d = 1'b1;
        state_d    = S_LOAD;
      end
      S_LOAD: if (tx_valid_q && tx_ready) begin
        sh_d  = {sh_q[247:0], 8'h00};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          tx_valid_d = 1'b0;
          opcode_d   = OP_HASH;
          cnt_d      = '0;
          state_d    = S_HASH;
        end
      end
      // cnt_q doubles as the HASH hold counter
      S_HASH: begin
        if (cnt_q == 6'(HASH_HOLD - 1)) begin
          cnt_d      = '0;
          opcode_d   = OP_WR_RES;
          src_d      = ID_SHA;
          dst_d      = ID_MEM;
          rx_ready_d = 1'b1;
          state_d    = S_RD_RES;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_RD_RES: if (rx_valid) begin
        cap_d = {cap_q[247:0], rx_data};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          cnt_d       = '0;
          rx_ready_d  = 1'b0;
          opcode_d    = OP_NEUTRAL;
          src_d       = ID_MEM;
          dst_d       = ID_MEM;
          ack_ready_d = 1'b1;
          state_d     = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: if (ack_valid) begin
        ack_ready_d = 1'b0;
        if (ack_source_id == ID_SHA) begin
          digest_d = cap_q;
          done_d   = 1'b1;
        end else begin
          error_d  = 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SHA_MASTER_TIMEOUT_EN
    // a byte or ack landing on the expiry cycle still counts as progress
    progress = (state_q == S_LOAD     && tx_valid_q && tx_ready) ||
               (state_q == S_RD_RES   && rx_valid) ||
               (state_q == S_WAIT_ACK && ack_valid);
    wd_d = (progress || state_d != state_q) ? 16'd0 : wd_q + 16'd1;
    if ((state_q == S_LOAD || state_q == S_RD_RES || state_q == S_WAIT_ACK) &&
        !progress && wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
      opcode_d    = OP_NEUTRAL;
      src_d       = ID_MEM;
      dst_d       = ID_MEM;
      tx_valid_d  = 1'b0;
      rx_ready_d  = 1'b0;
      ack_ready_d = 1'b0;
      cnt_d       = '0;
      error_d     = 1'b1;
      state_d     = S_DONE;
      wd_d        = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sh_q        <= '0;
      cap_q       <= '0;
      digest_q    <= '0;
      cnt_q       <= '0;
      opcode_q    <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      tx_valid_q  <= 1'b0;
      rx_ready_q  <= 1'b0;
      ack_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cap_q       <= cap_d;
      digest_q    <= digest_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      tx_valid_q  <= tx_valid_d;
      rx_ready_q  <= rx_ready_d;
      ack_ready_q <= ack_ready_d;
    end
  end

`ifdef SHA_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign digest    = digest_q;
  assign opcode    = opcode_q;
  assign source_id = src_q;
  assign dest_id   = dst_q;
  assign encdec    = 1'b0;
  assign addr      = '0;
  assign tx_data   = sh_q[255:248];
  assign tx_valid  = tx_valid_q;
  assign rx_ready  = rx_ready_q;
  assign ack_ready = ack_ready_q;

endmodule

// File: tb/tb_sha_txn_master.sv
// Directed bench for sha_txn_master: cycle table for the ideal exchange plus
// reactive-responder sequences for stalls, bad ack source, reset abort and timeout.
module tb_sha_txn_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] msg;
  logic         busy, done, error;
  logic [255:0] digest;
  logic [1:0]   opcode, source_id, dest_id;
  logic         encdec;
  logic [23:0]  addr;
  logic [7:0]   tx_data;
  logic         tx_valid, tx_ready;
  logic [7:0]   rx_data;
  logic         rx_valid, rx_ready;
  logic         ack_valid, ack_ready;
  logic [1:0]   ack_source_id;

  always #5 clk = ~clk;

  sha_txn_master #(.HASH_HOLD(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg(msg), .busy(busy), .done(done),
    .error(error), .digest(digest), .opcode(opcode), .source_id(source_id),
    .dest_id(dest_id), .encdec(encdec), .addr(addr), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .ack_valid(ack_valid), .ack_ready(ack_ready),
    .ack_source_id(ack_source_id)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    ack_valid = 1'b0; ack_source_id = 2'b00;
  endtask

  typedef struct {
    int         cyc;
    logic [1:0] op, src, dst;
    logic       txv, rxr, ackr, bsy, dn, err;
  } vec_t;

  function automatic vec_t mk(input int c, input logic [1:0] op, input logic [1:0] s,
                              input logic [1:0] d, input logic txv, input logic rxr,
                              input logic ackr, input logic bsy, input logic dn, input logic err);
    vec_t v;
    v.cyc = c; v.op = op; v.src = s; v.dst = d; v.txv = txv; v.rxr = rxr;
    v.ackr = ackr; v.bsy = bsy; v.dn = dn; v.err = err;
    return v;
  endfunction

  function automatic logic [255:0] seq_bytes(input int base);
    logic [255:0] r = '0;
    for (int i = 0; i < 32; i++) r = {r[247:0], 8'(base + i)};
    return r;
  endfunction

  // Drives one exchange with a reactive responder; returns after done/error,
  // after abort_rx digest bytes were accepted, or when the cycle budget runs out.
  task automatic run_txn(input logic [255:0] m, input logic [1:0] ack_id, input bit stall,
                         input int rx_base, input int abort_rx,
                         output int ntx, output int nrx, output int lat,
                         output bit got_done, output bit got_err, output bit seq_ok,
                         output bit finished);
    logic [3:0] pat = 4'b1001;
    ntx = 0; nrx = 0; lat = 0; got_done = 0; got_err = 0; seq_ok = 1; finished = 0;
    idle_inputs();
    start = 1'b1; msg = m;
    tick();
    start = 1'b0;
    lat = 1;
    while (lat < 400) begin
      if (done || error) begin
        got_done = done; got_err = error; finished = 1;
        idle_inputs();
        break;
      end
      if (abort_rx > 0 && nrx == abort_rx) begin
        finished = 1;
        idle_inputs();
        break;
      end
      tx_ready = stall ? pat[(lat - 1) % 4] : 1'b1;
      if (tx_valid && tx_ready) begin
        if (ntx >= 32 || tx_data !== m[255 - 8*ntx -: 8]) seq_ok = 0;
        ntx++;
      end
      rx_valid = rx_ready;
      rx_data  = 8'(rx_base + nrx);
      if (rx_ready) nrx++;
      ack_valid     = ack_ready;
      ack_source_id = ack_id;
      tick();
      lat++;
    end
    if (!finished) begin
      n_cmp++; n_bad++;
      $display("FAIL run_txn_budget: got no completion within %0d cycles, expected completion", lat);
    end
  endtask

  vec_t tbl[$];
  logic [255:0] m0, dig0;
  int ntx, nrx, lat;
  bit gd, ge, sok, fin;

  initial begin
    m0   = seq_bytes(8'h00);
    dig0 = seq_bytes(8'hA0);
    //           cyc op     src    dst    txv rxr ackr bsy dn  err
    tbl.push_back(mk( 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 1, 2'b01, 2'b00, 2'b01, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(32, 2'b01, 2'b00, 2'b01, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(33, 2'b11, 2'b00, 2'b01, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(34, 2'b11, 2'b00, 2'b01, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(35, 2'b10, 2'b01, 2'b00, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(66, 2'b10, 2'b01, 2'b00, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(67, 2'b00, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(68, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(69, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));

    // reset state
    rst_n = 1'b0; msg = '0; idle_inputs();
    tick(); tick();
    chk("reset_outputs", {busy, done, error, digest, opcode, source_id, dest_id, encdec,
                          addr, tx_data, tx_valid, rx_ready, ack_ready}, '0);
    rst_n = 1'b1;
    tick();

    // ideal exchange, cycle-accurate table
    msg = m0;
    for (int c = 0; c <= 70; c++) begin
      foreach (tbl[i]) if (tbl[i].cyc == c)
        chk($sformatf("vec_c%0d", c),
            {opcode, source_id, dest_id, tx_valid, rx_ready, ack_ready, busy, done, error},
            {tbl[i].op, tbl[i].src, tbl[i].dst, tbl[i].txv, tbl[i].rxr, tbl[i].ackr,
             tbl[i].bsy, tbl[i].dn, tbl[i].err});
      if (c >= 1 && c <= 32) chk($sformatf("tx_byte_c%0d", c), tx_data, 8'(c - 1));
      start     = (c == 0);
      tx_ready  = 1'b1;
      rx_valid  = (c >= 35 && c <= 66);
      rx_data   = 8'(160 + c - 35);
      ack_valid = (c == 67);
      ack_source_id = 2'b01;
      tick();
    end
    chk("ideal_digest", digest, dig0);
    chk("const_encdec_addr", {encdec, addr}, '0);

    // tx_ready 1,0,0,1 stalls, ack from MEM -> error, digest retained
    run_txn(seq_bytes(8'h40), 2'b00, 1'b1, 8'h50, 0, ntx, nrx, lat, gd, ge, sok, fin);
    chk("stall_ntx", ntx, 32);
    chk("stall_seq_ok", sok, 1);
    chk("bad_ack_err_done", {ge, gd}, 2'b10);
    chk("bad_ack_digest_kept", digest, dig0);
    tick();
    chk("bad_ack_busy_low", busy, 0);

    // reactive ideal run: latency 1+32+2+32+1
    run_txn(seq_bytes(8'h20), 2'b01, 1'b0, 8'h60, 0, ntx, nrx, lat, gd, ge, sok, fin);
    chk("ideal_latency", lat, 68);
    chk("ideal2_done", {gd, ge}, 2'b10);
    chk("ideal2_digest", digest, seq_bytes(8'h60));
    tick();
    chk("ideal2_busy_low", busy, 0);

    // reset in RD_RES after 10 digest bytes, then a fresh transaction
    run_txn(seq_bytes(8'h80), 2'b01, 1'b0, 8'h70, 10, ntx, nrx, lat, gd, ge, sok, fin);
    chk("pre_reset_in_rdres", {busy, rx_ready, opcode}, {1'b1, 1'b1, 2'b10});
    rst_n = 1'b0;
    #2;
    chk("mid_reset_outputs", {busy, done, error, digest, opcode, source_id, dest_id,
                              tx_data, tx_valid, rx_ready, ack_ready}, '0);
    tick();
    chk("mid_reset_held", {busy, digest, opcode, tx_valid, rx_ready}, '0);
    rst_n = 1'b1;
    run_txn(seq_bytes(8'hC0), 2'b01, 1'b0, 8'h33, 0, ntx, nrx, lat, gd, ge, sok, fin);
    chk("post_reset_seq_ok", {sok, 6'(ntx)}, {1'b1, 6'd32});
    chk("post_reset_digest", digest, seq_bytes(8'h33));
    tick();

`ifdef SHA_MASTER_TIMEOUT_EN
    // tx_ready stuck low: error at cycle 17, neutral bus, then normal retry
    begin
      int err_cyc = -1;
      idle_inputs();
      start = 1'b1; msg = seq_bytes(8'h11);
      for (int c = 0; c <= 20; c++) begin
        if (error && err_cyc < 0) begin
          err_cyc = c;
          chk("timeout_bus_neutral", {opcode, source_id, dest_id, tx_valid, busy},
              {2'b00, 2'b00, 2'b00, 1'b0, 1'b1});
        end
        if (c == 18) chk("timeout_busy_low", busy, 0);
        tick();
        start = 1'b0;
      end
      chk("timeout_err_cycle", err_cyc, 17);
      run_txn(seq_bytes(8'h11), 2'b01, 1'b0, 8'h90, 0, ntx, nrx, lat, gd, ge, sok, fin);
      chk("timeout_retry", {gd, ge, sok}, 3'b101);
      chk("timeout_retry_digest", digest, seq_bytes(8'h90));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
